cmd_decoder: RTL and testbench
==============================

Name: cmd_decoder

Overview:
Generalised host-command decoder that consumes the byte stream from the RX FIFO and turns it into control actions. Packet format is one command byte, optionally followed by PAYLOAD_BYTES payload bytes. It drives one-cycle action strobes, a parametric register file, and a forward channel with busy-wait handshake toward peripheral config blocks. It also drives a FIFO reset pulse and error reporting with a payload-timeout abort. It sits between the RX FIFO read side and the peripheral sr_latch set inputs in top.

Parameters:
N_ACT, 8, number of action commands (opcodes 0x01..N_ACT), 1..127
PAYLOAD_BYTES, 2, payload length in bytes for opcodes 0x80/0x81, 2..4
NUM_REGS, 4, register-file depth, power of two, at most 256
REG_ADDR_W, 2, log2(NUM_REGS)
TIMEOUT_CYCLES, 1000000, maximum clk cycles to wait for each payload byte
RST_CYCLES, 4, length of the fifo_rst_n low pulse

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
rx_rdata  in  8  RX FIFO head byte; valid whenever rx_rempty=0
rx_rempty  in  1  RX FIFO empty
rx_rinc  out  1  consume head byte; combinational
act_pulse  out  N_ACT  one-cycle action strobes; bit i = opcode i+1
reg_flat  out  NUM_REGS*8*(PAYLOAD_BYTES-1)  register file, reg k at slice k
fwd_data  out  8*PAYLOAD_BYTES  forwarded payload, big-endian
fwd_valid  out  1  one-cycle strobe that fwd_data is new
fwd_busy  in  1  destination busy or request pending
fifo_rst_n  out  1  active-low FIFO reset pulse
err_cmd  out  1  one-cycle strobe on unknown opcode
err_timeout  out  1  one-cycle strobe on payload timeout
err_count  out  8  saturating error counter
state_dbg  out  4  current state encoding, for the debug port

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. All registers, payload shift register and err_count go to 0. act_pulse=0, fwd_valid=0, err_*=0, fifo_rst_n=1. Reset mid-packet discards the partial packet; bytes already consumed are not replayed.
- rx_rinc = (state==IDLE or state==PAYLOAD) and rx_rempty==0. The byte is captured on the same edge. rx_rinc is never asserted while empty.
- IDLE: on a byte, latch cmd, clear byte count and timer, then go to DECODE. Throughput is at most 1 byte/cycle.
- DECODE (1 cycle), by opcode:
  - 0x00: NOP, back to IDLE.
  - 0x01..N_ACT: act_pulse[cmd-1]=1 for exactly the next cycle (registered), back to IDLE.
  - 0x80 or 0x81: go to PAYLOAD.
  - 0xFF: go to FIFORST.
  - Any other opcode: err_cmd=1 for one cycle, err_count+1, back to IDLE.
  - Latency from command-byte consumption to act_pulse is 2 cycles.
- PAYLOAD: shift each byte in MSB-first. The timer counts cycles while empty and resets on every byte.
  - After PAYLOAD_BYTES bytes: 0x80 goes to WRITE, 0x81 goes to FWDWAIT.
  - If the timer reaches TIMEOUT_CYCLES-1 while empty: err_timeout=1 for one cycle, err_count+1, back to IDLE, partial payload discarded.
- WRITE (1 cycle): byte0 = address. addr[REG_ADDR_W-1:0] selects the register; the remaining bytes are its data.
  - If address >= NUM_REGS: no write, err_cmd strobe, err_count+1.
  - Back to IDLE.
- FWDWAIT: hold while fwd_busy=1. No timeout and no further FIFO reads in this state. When fwd_busy=0: fwd_data=payload, fwd_valid=1 for one cycle, back to IDLE.
  - fwd_data holds its value until the next forward.
- FIFORST: fifo_rst_n=0 for exactly RST_CYCLES cycles (counter), then back to IDLE. rx_rinc is held 0 during this state. Register file contents persist.
- err_count saturates at 0xFF.
- err_cmd and err_timeout are never asserted in the same cycle.
- state_dbg encoding: IDLE=1, DECODE=2, PAYLOAD=6, WRITE=10, FWDWAIT=13, FIFORST=0.

Test Plan:
- Reset, then bytes 0x03 ->
  - act_pulse=0x04 for exactly one cycle, 2 cycles after rx_rinc;
  - all other outputs unchanged.
- Defaults, bytes 0x80 0x02 0xA5 -> reg_flat[23:16]=0xA5, other registers 0. Then bytes 0x80 0x07 0x11 -> no write, err_cmd strobe, err_count=1.
- Bytes 0x81 0x12 0x34 with fwd_busy=1 for 20 cycles ->
  - no fwd_valid while busy;
  - fwd_valid for exactly 1 cycle with fwd_data=0x1234 after busy drops;
  - rx_rinc stays 0 meanwhile.
- TIMEOUT_CYCLES=16, bytes 0x80 0x01, then FIFO empty -> err_timeout after 16 empty cycles, state returns to IDLE. A following 0x01 gives act_pulse[0].
- Bytes 0x55, then 0xFF -> err_cmd once, then fifo_rst_n low for exactly 4 cycles; reg_flat unchanged.
- Assert rst_n=0 mid-payload after 0x81 0x12 -> no fwd_valid, err_count=0. A subsequent 0x81 0xAB 0xCD forwards 0xABCD.
- Bench streams 300 unknown opcodes back-to-back -> err_count=0xFF, no wrap.

Source files
------------

// File: rtl/cmd_decoder.sv
// Host-command decoder: turns the RX FIFO byte stream into action strobes,
// register-file writes, payload forwards and FIFO reset pulses.
module cmd_decoder #(
  parameter int N_ACT          = 8,
  parameter int PAYLOAD_BYTES  = 2,
  parameter int NUM_REGS       = 4,
  parameter int REG_ADDR_W     = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RST_CYCLES     = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [7:0]                             rx_rdata,
  input  logic                                   rx_rempty,
  output logic                                   rx_rinc,
  output logic [N_ACT-1:0]                       act_pulse,
  output logic [NUM_REGS*8*(PAYLOAD_BYTES-1)-1:0] reg_flat,
  output logic [8*PAYLOAD_BYTES-1:0]             fwd_data,
  output logic                                   fwd_valid,
  input  logic                                   fwd_busy,
  output logic                                   fifo_rst_n,
  output logic                                   err_cmd,
  output logic                                   err_timeout,
  output logic [7:0]                             err_count,
  output logic [3:0]                             state_dbg
);

  localparam int DATA_W = 8 * (PAYLOAD_BYTES - 1);
  localparam int PAY_W  = 8 * PAYLOAD_BYTES;
  localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [2:0]       BYTE_LAST = 3'(PAYLOAD_BYTES - 1);

  typedef enum logic [3:0] {
    S_FIFORST = 4'd0,
    S_IDLE    = 4'd1,
    S_DECODE  = 4'd2,
    S_PAYLOAD = 4'd6,
    S_WRITE   = 4'd10,
    S_FWDWAIT = 4'd13
  } state_t;

  state_t             state;
  logic [7:0]         cmd;
  logic [PAY_W-1:0]   payload;
  logic [2:0]         byte_cnt;
  logic [TMR_W-1:0]   timer;
  logic [RST_W-1:0]   rst_cnt;
  logic [DATA_W-1:0]  regs [NUM_REGS];

  logic [N_ACT-1:0]      act_onehot;
  logic                  is_act;
  logic [7:0]            wr_byte;
  logic                  addr_ok;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [7:0]            err_count_inc;

  assign rx_rinc   = ((state == S_IDLE) || (state == S_PAYLOAD)) && !rx_rempty;
  assign state_dbg = state;

  assign is_act     = (cmd != 8'h00) && (int'(cmd) <= N_ACT);
  assign act_onehot = N_ACT'(1) << (cmd - 8'd1);

  // The first payload byte sits in the top byte of the shift register.
  assign wr_byte = payload[PAY_W-1 -: 8];
  assign addr_ok = int'(wr_byte) < NUM_REGS;
  assign wr_addr = wr_byte[REG_ADDR_W-1:0];
  assign wr_data = payload[DATA_W-1:0];

  assign err_count_inc = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_flat[g*DATA_W +: DATA_W] = regs[g];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd         <= '0;
      payload     <= '0;
      byte_cnt    <= '0;
      timer       <= '0;
      rst_cnt     <= '0;
      act_pulse   <= '0;
      fwd_data    <= '0;
      fwd_valid   <= 1'b0;
      fifo_rst_n  <= 1'b1;
      err_cmd     <= 1'b0;
      err_timeout <= 1'b0;
      err_count   <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
    end else begin
      act_pulse   <= '0;
      fwd_valid   <= 1'b0;
      err_cmd     <= 1'b0;
      err_timeout <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_rempty) begin
            cmd      <= rx_rdata;
            byte_cnt <= '0;
            timer    <= '0;
            state    <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (cmd == 8'h00) begin
            state <= S_IDLE;
          end else if (is_act) begin
            act_pulse <= act_onehot;
            state     <= S_IDLE;
          end else if ((cmd == 8'h80) || (cmd == 8'h81)) begin
            byte_cnt <= '0;
            timer    <= '0;
            state    <= S_PAYLOAD;
          end else if (cmd == 8'hFF) begin
            fifo_rst_n <= 1'b0;
            rst_cnt    <= '0;
            state      <= S_FIFORST;
          end else begin
            err_cmd   <= 1'b1;
            err_count <= err_count_inc;
            state     <= S_IDLE;
          end
        end

        // The timer only advances on empty cycles; every byte restarts it.
        S_PAYLOAD: begin
          if (!rx_rempty) begin
            payload <= {payload[PAY_W-9:0], rx_rdata};
            timer   <= '0;
            if (byte_cnt == BYTE_LAST) begin
              state <= cmd[0] ? S_FWDWAIT : S_WRITE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end else if (timer == TMR_LAST) begin
            err_timeout <= 1'b1;
            err_count   <= err_count_inc;
            payload     <= '0;
            state       <= S_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        S_WRITE: begin
          if (addr_ok) begin
            regs[wr_addr] <= wr_data;
          end else begin
            err_cmd   <= 1'b1;
            err_count <= err_count_inc;
          end
          state <= S_IDLE;
        end

        S_FWDWAIT: begin
          if (!fwd_busy) begin
            fwd_data  <= payload;
            fwd_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end

        S_FIFORST: begin
          if (rst_cnt == RST_LAST) begin
            fifo_rst_n <= 1'b1;
            state      <= S_IDLE;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder: a queue-backed RX FIFO feeds bytes and a
// scoreboard of expected output events is drained by a per-cycle monitor.
module tb_cmd_decoder;

  localparam int EV_ACT = 0;
  localparam int EV_FWD = 1;
  localparam int EV_ERC = 2;
  localparam int EV_TMO = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_rdata;
  logic        rx_rempty;
  logic        rx_rinc;
  logic [7:0]  act_pulse;
  logic [31:0] reg_flat;
  logic [15:0] fwd_data;
  logic        fwd_valid;
  logic        fwd_busy = 1'b0;
  logic        fifo_rst_n;
  logic        err_cmd;
  logic        err_timeout;
  logic [7:0]  err_count;
  logic [3:0]  state_dbg;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  ev_t         sb[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  exp_err = 8'h00;
  logic [31:0] exp_regs = 32'h0;

  logic [7:0]  rx_mem [2048];
  logic [10:0] wr_ptr = 11'd0;
  logic [10:0] rd_ptr = 11'd0;

  cmd_decoder #(
    .N_ACT(8), .PAYLOAD_BYTES(2), .NUM_REGS(4), .REG_ADDR_W(2),
    .TIMEOUT_CYCLES(16), .RST_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdata(rx_rdata), .rx_rempty(rx_rempty),
    .rx_rinc(rx_rinc), .act_pulse(act_pulse), .reg_flat(reg_flat),
    .fwd_data(fwd_data), .fwd_valid(fwd_valid), .fwd_busy(fwd_busy),
    .fifo_rst_n(fifo_rst_n), .err_cmd(err_cmd), .err_timeout(err_timeout),
    .err_count(err_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign rx_rempty = (wr_ptr == rd_ptr);
  assign rx_rdata  = rx_mem[rd_ptr];

  always @(posedge clk) begin
    if (rx_rinc && !rx_rempty) rd_ptr <= rd_ptr + 11'd1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 11'd1;
  endtask

  task automatic expectEvent(input int kind, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic popEvent(input int kind, input logic [15:0] val, input string tag);
    ev_t e;
    checkOutput({tag, " expected-pending"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput({tag, " kind"}, 64'(kind), 64'(e.kind));
      checkOutput({tag, " value"}, 64'(val), 64'(e.val));
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      step();
      if (rx_rempty && sb.size() == 0 && state_dbg == 4'd1) break;
    end
    checkOutput({tag, " drain"}, 64'(i < budget), 64'd1);
  endtask

  // Monitor: samples well after the negedge so stimulus changes have settled.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      checkOutput("rinc_while_empty", 64'(rx_rinc && rx_rempty), 64'd0);
      checkOutput("err_overlap", 64'(err_cmd && err_timeout), 64'd0);
      if (act_pulse != 8'h00) popEvent(EV_ACT, {8'h00, act_pulse}, "act_event");
      if (fwd_valid)          popEvent(EV_FWD, fwd_data, "fwd_event");
      if (err_cmd)            popEvent(EV_ERC, {8'h00, err_count}, "errcmd_event");
      if (err_timeout)        popEvent(EV_TMO, {8'h00, err_count}, "timeout_event");
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int low_cnt;

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checkOutput("rst act_pulse", act_pulse, 0);
    checkOutput("rst fwd_valid", fwd_valid, 0);
    checkOutput("rst err_cmd", err_cmd, 0);
    checkOutput("rst err_timeout", err_timeout, 0);
    checkOutput("rst fifo_rst_n", fifo_rst_n, 1);
    checkOutput("rst err_count", err_count, 0);
    checkOutput("rst reg_flat", reg_flat, 0);
    checkOutput("rst state_dbg", state_dbg, 1);
    checkOutput("rst rx_rinc", rx_rinc, 0);

    // Action opcode 0x03 with two-cycle latency from the consuming cycle
    $display("[TB] action command");
    applyStimulus(8'h03);
    expectEvent(EV_ACT, 16'h0004);
    #1;
    checkOutput("act rx_rinc", rx_rinc, 1);
    step();
    checkOutput("act early", act_pulse, 0);
    checkOutput("act decode state", state_dbg, 2);
    step();
    checkOutput("act pulse", act_pulse, 8'h04);
    checkOutput("act err_count", err_count, 0);
    checkOutput("act fifo_rst_n", fifo_rst_n, 1);
    checkOutput("act reg_flat", reg_flat, 0);
    step();
    checkOutput("act width", act_pulse, 0);
    drain(10, "act");

    // Register writes, in range and out of range
    $display("[TB] register writes");
    applyStimulus(8'h80); applyStimulus(8'h02); applyStimulus(8'hA5);
    exp_regs[23:16] = 8'hA5;
    drain(20, "write ok");
    checkOutput("write reg_flat", reg_flat, exp_regs);
    applyStimulus(8'h80); applyStimulus(8'h07); applyStimulus(8'h11);
    exp_err = 8'd1;
    expectEvent(EV_ERC, {8'h00, exp_err});
    drain(20, "write bad");
    checkOutput("bad write reg_flat", reg_flat, exp_regs);
    checkOutput("bad write err_count", err_count, exp_err);

    // Forward held off by fwd_busy; a queued byte must wait behind it
    $display("[TB] forward with busy");
    fwd_busy = 1'b1;
    applyStimulus(8'h81); applyStimulus(8'h12); applyStimulus(8'h34); applyStimulus(8'h05);
    expectEvent(EV_FWD, 16'h1234);
    expectEvent(EV_ACT, 16'h0010);
    for (int i = 1; i <= 20; i++) begin
      step();
      checkOutput("fwd while busy", fwd_valid, 0);
      if (i >= 4) checkOutput("rinc in fwdwait", rx_rinc, 0);
    end
    checkOutput("fwdwait state", state_dbg, 13);
    fwd_busy = 1'b0;
    step();
    checkOutput("fwd valid", fwd_valid, 1);
    checkOutput("fwd data", fwd_data, 16'h1234);
    step();
    checkOutput("fwd width", fwd_valid, 0);
    drain(10, "fwd");
    checkOutput("fwd data hold", fwd_data, 16'h1234);

    // Payload timeout after 16 empty cycles
    $display("[TB] payload timeout");
    applyStimulus(8'h80); applyStimulus(8'h01);
    exp_err = 8'd2;
    expectEvent(EV_TMO, {8'h00, exp_err});
    for (int i = 1; i <= 19; i++) begin
      step();
      if (i < 19) checkOutput("timeout early", err_timeout, 0);
      if (i == 18) checkOutput("timeout payload state", state_dbg, 6);
    end
    checkOutput("timeout strobe", err_timeout, 1);
    checkOutput("timeout state", state_dbg, 1);
    step();
    checkOutput("timeout width", err_timeout, 0);
    applyStimulus(8'h01);
    expectEvent(EV_ACT, 16'h0001);
    drain(10, "after timeout");
    checkOutput("timeout err_count", err_count, exp_err);

    // Unknown opcode, then FIFO reset pulse with a byte waiting behind it
    $display("[TB] unknown opcode and fifo reset");
    applyStimulus(8'h55); applyStimulus(8'hFF); applyStimulus(8'h02);
    exp_err = 8'd3;
    expectEvent(EV_ERC, {8'h00, exp_err});
    expectEvent(EV_ACT, 16'h0002);
    low_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (!fifo_rst_n) low_cnt++;
      if (i >= 4 && i <= 7) checkOutput("rinc in fiforst", rx_rinc, 0);
      if (i == 4) checkOutput("fiforst state", state_dbg, 0);
    end
    checkOutput("fifo_rst_n low cycles", 64'(low_cnt), 64'd4);
    drain(10, "fiforst");
    checkOutput("fiforst reg_flat", reg_flat, exp_regs);
    checkOutput("fiforst err_count", err_count, exp_err);

    // Reset in the middle of a forward payload
    $display("[TB] reset mid-payload");
    applyStimulus(8'h81); applyStimulus(8'h12);
    repeat (3) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    exp_err = 8'd0;
    exp_regs = 32'h0;
    step();
    checkOutput("midrst err_count", err_count, exp_err);
    checkOutput("midrst state", state_dbg, 1);
    checkOutput("midrst fwd_valid", fwd_valid, 0);
    checkOutput("midrst reg_flat", reg_flat, exp_regs);
    repeat (20) step();
    applyStimulus(8'h81); applyStimulus(8'hAB); applyStimulus(8'hCD);
    expectEvent(EV_FWD, 16'hABCD);
    drain(20, "post reset fwd");
    checkOutput("post reset fwd_data", fwd_data, 16'hABCD);

    // Saturation of the error counter
    $display("[TB] error counter saturation");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'(8'h40 + (i % 32)));
      exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
      expectEvent(EV_ERC, {8'h00, exp_err});
    end
    drain(1000, "saturate");
    checkOutput("err_count saturated", err_count, 8'hFF);

    checkOutput("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
